mem_port_arbiter: RTL and testbench

Shares the processor's single external memory port between the instruction-fetch requester and the data-memory requester. Requests are accepted with round-robin fairness, each winner is driven to memory with a req/ack handshake, and read data plus an ack or timeout-error pulse are returned to the owner. The block sits between the fetch/memory stages sequenced by `controlUnit` and the memory model.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal the arbiter exchanges with its two requesters and
// the memory. The master view belongs to the arbiter, which masters the
// memory port; the slave view belongs to the requesters plus memory around it.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    // fetch requester
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          if_err;
    // data requester
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          dm_err;
    // memory port
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    // status
    logic          owner;
    logic          busy;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ack, if_err, dm_rdata, dm_ack, dm_err,
               mem_req, mem_we, mem_addr, mem_wdata, owner, busy
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ack, if_err, dm_rdata, dm_ack, dm_err,
               mem_req, mem_we, mem_addr, mem_wdata, owner, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port between instruction
// fetch (owner 0) and data memory (owner 1). Each grant runs one req/ack
// handshake with a timeout, then reports ack or err to the owner.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    mem_port_arbiter_if.master  bus
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic          owner_q, owner_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          if_err_q, if_err_d;
    logic          dm_ack_q, dm_ack_d;
    logic          dm_err_q, dm_err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          win;

    // Next-state logic: arbitration in IDLE, handshake/timeout in ACCESS.
    always_comb begin
        // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_ack_d     = 1'b0;
        if_err_d     = 1'b0;
        dm_ack_d     = 1'b0;
        dm_err_d     = 1'b0;
        cnt_d        = cnt_q;
        // Data wins when alone, or on a tie when fetch was served last.
        win          = bus.dm_req & (~bus.if_req | ~last_owner_q);

        case (state_q)
            S_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    owner_d      = win;
                    last_owner_d = win;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = win ? bus.dm_addr : bus.if_addr;
                    mem_we_d     = win & bus.dm_we;
                    mem_wdata_d  = win ? bus.dm_wdata : '0;
                    cnt_d        = '0;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_DONE;
                    if (owner_q) begin
                        dm_ack_d = 1'b1;
                        // a write completes without touching the read data
                        if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    state_d   = S_DONE;
                    if (owner_q) dm_err_d = 1'b1;
                    else         if_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; async reset abandons any transaction and drops mem_req at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_owner_q <= 1'b0;
            owner_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            if_err_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            dm_err_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ack_q     <= if_ack_d;
            if_err_q     <= if_err_d;
            dm_ack_q     <= dm_ack_d;
            dm_err_q     <= dm_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_err    = if_err_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.dm_err    = dm_err_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A transaction-level model keeps
// the round-robin history and the rdata each requester should hold; every
// transaction is predicted from the arbitration rule, the wait count and the
// timeout limit, then checked cycle by cycle.
module tb_mem_port_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic clock;
    logic reset_n;
    int   n_vec;
    int   n_err;

    // reference model state
    bit            last_owner;
    logic [DW-1:0] exp_rd [2];

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog: the stimulus is bounded, this only guards against a stuck simulator.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        last_owner = 1'b0;
        exp_rd[0]  = '0;
        exp_rd[1]  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, bus.mem_req, 0);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_if_rdata"}, bus.if_rdata, 0);
        check({tag, "_dm_rdata"}, bus.dm_rdata, 0);
        check({tag, "_acks_errs"}, {bus.if_ack, bus.if_err, bus.dm_ack, bus.dm_err}, 0);
        check({tag, "_owner"}, bus.owner, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    // Runs one transaction from IDLE with at least one req already raised.
    // waits: memory wait states (>= TMO means the memory never answers).
    // keep:  winner's req stays high through its ack cycle.
    // stray: drive mem_ack during DONE, which must be ignored.
    task automatic run_txn(input int waits, input logic [DW-1:0] rdata,
                           input bit keep, input bit stray);
        bit            win;
        bit            we;
        bit            timed_out;
        int            nacc;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;

        if (bus.if_req && bus.dm_req) win = ~last_owner;
        else                          win = bus.dm_req;
        addr       = win ? bus.dm_addr : bus.if_addr;
        we         = win ? bus.dm_we : 1'b0;
        wdata      = bus.dm_wdata;
        last_owner = win;
        timed_out  = (waits >= TMO);
        nacc       = timed_out ? TMO : waits + 1;

        tick();  // grant edge E0
        for (int i = 1; i <= nacc; i++) begin
            check("acc_mem_req", bus.mem_req, 1);
            check("acc_mem_addr", bus.mem_addr, addr);
            check("acc_mem_we", bus.mem_we, we);
            if (win) check("acc_mem_wdata", bus.mem_wdata, wdata);
            check("acc_busy", bus.busy, 1);
            check("acc_owner", bus.owner, win);
            check("acc_no_resp", {bus.if_ack, bus.if_err, bus.dm_ack, bus.dm_err}, 0);
            bus.mem_ack   = (!timed_out && i == nacc);
            bus.mem_rdata = bus.mem_ack ? rdata : DW'($urandom);
            tick();
        end

        // DONE cycle
        bus.mem_ack   = stray;
        bus.mem_rdata = DW'($urandom);
        if (!timed_out && !we) exp_rd[win] = rdata;
        check("done_mem_req", bus.mem_req, 0);
        check("done_busy", bus.busy, 1);
        check("done_owner", bus.owner, win);
        check("done_if_ack", bus.if_ack, !win && !timed_out);
        check("done_dm_ack", bus.dm_ack, win && !timed_out);
        check("done_if_err", bus.if_err, !win && timed_out);
        check("done_dm_err", bus.dm_err, win && timed_out);
        check("done_if_rdata", bus.if_rdata, exp_rd[0]);
        check("done_dm_rdata", bus.dm_rdata, exp_rd[1]);
        if (!keep) begin
            if (win) bus.dm_req = 1'b0;
            else     bus.if_req = 1'b0;
        end
        tick();

        // back in IDLE
        bus.mem_ack = 1'b0;
        check("idle_busy", bus.busy, 0);
        check("idle_mem_req", bus.mem_req, 0);
        check("idle_no_resp", {bus.if_ack, bus.if_err, bus.dm_ack, bus.dm_err}, 0);
        check("idle_if_rdata", bus.if_rdata, exp_rd[0]);
        check("idle_dm_rdata", bus.dm_rdata, exp_rd[1]);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        model_reset();

        // reset values
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // fetch read, zero-wait memory
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        run_txn(0, 32'hDEADBEEF, 1'b0, 1'b0);

        // data write with 3 wait states: command held for 4 ACCESS cycles
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 16'h0200;
        bus.dm_wdata = 32'h12345678;
        run_txn(3, 32'hA5A5A5A5, 1'b0, 1'b0);

        // memory never acks: timeout err at E4, stray ack in DONE ignored
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 16'h0300;
        run_txn(99, 32'h0BADF00D, 1'b0, 1'b1);
        tick();
        check("post_timeout_idle", bus.busy, 0);

        // reset pulled mid-ACCESS: outputs drop at once, no ack/err
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0444;
        tick();
        check("pre_rst_mem_req", bus.mem_req, 1);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        model_reset();
        bus.if_req = 1'b0;
        tick();
        check("in_rst_no_resp", {bus.if_ack, bus.if_err}, 0);
        reset_n = 1'b1;
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0048;
        run_txn(1, 32'hCAFEF00D, 1'b0, 1'b0);

        // fresh reset, both requesting and held: data, fetch, data, fetch
        reset_n = 1'b0;
        tick();
        model_reset();
        reset_n = 1'b1;
        tick();
        bus.if_req   = 1'b1;
        bus.if_addr  = 16'h0100;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 16'h0800;
        for (int k = 0; k < 4; k++) begin
            run_txn(k % 2, 32'h1000_0000 + 32'(k), 1'b1, 1'b0);
            check("tie_alternate", bus.dm_req & bus.if_req, 1);
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        tick();

        // req kept high through the ack-ending edge is a new request
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0060;
        run_txn(0, 32'h11112222, 1'b1, 1'b0);
        run_txn(0, 32'h33334444, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("single_after_drop", {bus.mem_req, bus.busy}, 0);
            tick();
        end

        // randomized traffic with random waits, some beyond the timeout
        for (int n = 0; n < 40; n++) begin
            if (!bus.if_req && $urandom_range(0, 1) == 1) begin
                bus.if_req  = 1'b1;
                bus.if_addr = AW'($urandom);
            end
            if (!bus.dm_req && $urandom_range(0, 1) == 1) begin
                bus.dm_req   = 1'b1;
                bus.dm_we    = 1'($urandom_range(0, 1));
                bus.dm_addr  = AW'($urandom);
                bus.dm_wdata = DW'($urandom);
            end
            if (!bus.if_req && !bus.dm_req) begin
                bus.if_req  = 1'b1;
                bus.if_addr = AW'($urandom);
            end
            run_txn($urandom_range(0, 5), DW'($urandom),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        tick();
        check("final_idle", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
